// File: rtl/cd_spi_bridge.sv
// cd_spi_bridge: SPI mode-0 slave, oversampled in the clk domain, that turns host frames into CSR strobes.
// Build macro CD_SPI_AUTO_INC_EN enables csr_address post-increment after each data byte.
module cd_spi_bridge #(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              spi_ss_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              chip_select,
  output logic [ADDR_W-1:0] csr_address,
  output logic              csr_read,
  output logic              csr_write,
  output logic [7:0]        csr_writedata,
  input  logic [7:0]        csr_readdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA
  } state_t;

`ifdef CD_SPI_AUTO_INC_EN
  localparam bit AUTO_INC = 1'b1;
`else
  localparam bit AUTO_INC = 1'b0;
`endif

  // Data FIFO window: repeated accesses must hit the same register.
  localparam logic [ADDR_W-1:0] FIFO_ADDR = ADDR_W'(21);

  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sclk_prev;
  logic                   r_armed;

  logic                   w_ss;
  logic                   w_sclk;
  logic                   w_mosi;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_rise_ok;
  logic                   w_byte_done;
  logic [7:0]             w_byte;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [2:0]             r_bit_cnt;
  logic [6:0]             r_rx_shift;
  logic [7:0]             r_tx_shift;
  logic [7:0]             r_csr_writedata;
  logic [ADDR_W-1:0]      r_csr_address;
  logic                   r_csr_read;
  logic                   r_csr_write;
  logic                   r_load;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the ss synchroniser resets to "selected" and r_armed stays low until a real
      // deselect is observed, so a frame already in flight at reset release is ignored.
      r_ss_sync   <= '0;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous value of its neighbour.
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], spi_ss_n};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_prev <= w_sclk;
      r_armed     <= r_armed | w_ss;
    end
  end

  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise      = w_sclk & ~r_sclk_prev;
  assign w_fall      = ~w_sclk & r_sclk_prev;
  // A deselect in the same cycle as an edge wins: the edge is ignored.
  assign w_rise_ok   = w_rise & ~w_ss & (r_state != ST_IDLE);
  assign w_byte_done = w_rise_ok & (r_bit_cnt == 3'd7);
  assign w_byte      = {r_rx_shift, w_mosi};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns w_next_state and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_armed && !w_ss) begin
          w_next_state = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (w_ss) begin
          w_next_state = ST_IDLE;
        end else if (w_byte_done) begin
          w_next_state = w_byte[7] ? ST_WDATA : ST_RDATA;
        end
      end
      ST_WDATA, ST_RDATA: begin
        if (w_ss) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt       <= '0;
      r_rx_shift      <= '0;
      r_tx_shift      <= '0;
      r_csr_writedata <= '0;
      r_csr_address   <= '0;
      r_csr_read      <= 1'b0;
      r_csr_write     <= 1'b0;
      r_load          <= 1'b0;
    end else begin
      if (w_ss) begin
        r_bit_cnt <= '0;
      end else if (w_rise_ok) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      if (w_rise_ok) begin
        r_rx_shift <= w_byte[6:0];
      end

      r_csr_write <= (r_state == ST_WDATA) && w_byte_done;
      // The read strobe marks the byte as consumed on its first bit.
      r_csr_read  <= (r_state == ST_RDATA) && w_rise_ok && (r_bit_cnt == 3'd0);
      r_load      <= ((r_state == ST_ADDR) && w_byte_done && !w_byte[7]) ||
                     ((r_state == ST_RDATA) && w_byte_done);

      if ((r_state == ST_WDATA) && w_byte_done) begin
        r_csr_writedata <= w_byte;
      end

      // Skipping the shift at bit_cnt 0 keeps a freshly loaded MSB on MISO for the host.
      if (r_load) begin
        r_tx_shift <= csr_readdata;
      end else if ((r_state == ST_RDATA) && w_fall && (r_bit_cnt != 3'd0)) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end

      if (AUTO_INC && (r_csr_write || r_csr_read) && (r_csr_address != FIFO_ADDR)) begin
        r_csr_address <= r_csr_address + ADDR_W'(1);
      end
      if ((r_state == ST_ADDR) && w_byte_done) begin
        r_csr_address <= w_byte[ADDR_W-1:0];
      end
    end
  end

  assign chip_select   = r_armed & ~w_ss;
  assign spi_miso_oe   = chip_select;
  assign spi_miso      = (r_state == ST_RDATA) & r_tx_shift[7];
  assign csr_address   = r_csr_address;
  assign csr_read      = r_csr_read;
  assign csr_write     = r_csr_write;
  assign csr_writedata = r_csr_writedata;

endmodule

// File: tb/tb_cd_spi_bridge.sv
// Directed bench for cd_spi_bridge: a bit-banged SPI host plus a small CSR model and strobe logger.
// Expectations for the CD_SPI_AUTO_INC_EN build are selected by the same macro.
module tb_cd_spi_bridge;

  localparam int SYNC_STAGES = 2;
  localparam int ADDR_W      = 5;
  localparam int HALF        = 6;
`ifdef CD_SPI_AUTO_INC_EN
  localparam int INC = 1;
`else
  localparam int INC = 0;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic              spi_ss_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              chip_select;
  logic [ADDR_W-1:0] csr_address;
  logic              csr_read;
  logic              csr_write;
  logic [7:0]        csr_writedata;
  logic [7:0]        csr_readdata;

  int n_cmp = 0;
  int n_err = 0;

  int n_writes = 0;
  int n_reads  = 0;
  int both_err = 0;
  int rd_base  = 0;
  int rd_off;
  logic [1:0]        rd_sel;
  logic [7:0]        rd_vals [4];
  logic [ADDR_W-1:0] wr_addr [64];
  logic [7:0]        wr_data [64];
  logic [ADDR_W-1:0] rd_addr [64];

  always #5 clk = ~clk;

  cd_spi_bridge #(.SYNC_STAGES(SYNC_STAGES), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .spi_ss_n      (spi_ss_n),
    .spi_sclk      (spi_sclk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .spi_miso_oe   (spi_miso_oe),
    .chip_select   (chip_select),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata)
  );

  // CSR model: presents rd_vals in order, advancing on every csr_read.
  assign rd_off       = n_reads - rd_base;
  assign rd_sel       = (rd_off > 3) ? 2'd3 : rd_off[1:0];
  assign csr_readdata = rd_vals[rd_sel];

  always @(negedge clk) begin
    if (csr_write && n_writes < 64) begin
      wr_addr[n_writes] <= csr_address;
      wr_data[n_writes] <= csr_writedata;
    end
    if (csr_read && n_reads < 64) begin
      rd_addr[n_reads] <= csr_address;
    end
    if (csr_write) n_writes <= n_writes + 1;
    if (csr_read)  n_reads  <= n_reads + 1;
    if (csr_read && csr_write) both_err <= both_err + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = '0;
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = tx[i];
      tick(HALF);
      rx[i] = spi_miso;
      spi_sclk = 1'b1;
      tick(HALF);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic start_frame();
    spi_ss_n = 1'b0;
    tick(HALF);
  endtask

  task automatic end_frame();
    tick(HALF);
    spi_ss_n = 1'b1;
    tick(SYNC_STAGES + 4);
  endtask

  task automatic test_reset();
    logic [17:0] outs;
    reset_n  = 1'b0;
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    rd_vals  = '{8'h00, 8'h00, 8'h00, 8'h00};
    tick(4);
    outs = {spi_miso, spi_miso_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata};
    n_cmp++;
    if (outs !== 18'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected 00000", outs);
    end
    reset_n = 1'b1;
    tick(SYNC_STAGES + 4);
    n_cmp++;
    if (chip_select !== 1'b0) begin
      n_err++;
      $display("FAIL idle_chip_select: got %b expected 0", chip_select);
    end
  endtask

  task automatic test_write_burst();
    logic [7:0] rx0, rx1, rx2;
    int wb, rb;
    wb = n_writes;
    rb = n_reads;
    start_frame();
    n_cmp++;
    if ({chip_select, spi_miso_oe} !== 2'b11) begin
      n_err++;
      $display("FAIL wr_select: got %b expected 11", {chip_select, spi_miso_oe});
    end
    spi_bits(8'h82, 8, rx0);
    spi_bits(8'h0a, 8, rx1);
    spi_bits(8'h0b, 8, rx2);
    end_frame();
    n_cmp++;
    if (n_writes - wb !== 2) begin
      n_err++;
      $display("FAIL wr_count: got %0d expected 2", n_writes - wb);
    end
    n_cmp++;
    if ({wr_addr[wb], wr_data[wb]} !== {5'h02, 8'h0a}) begin
      n_err++;
      $display("FAIL wr_first: got addr %h data %h expected addr 02 data 0a", wr_addr[wb], wr_data[wb]);
    end
    n_cmp++;
    if ({wr_addr[wb+1], wr_data[wb+1]} !== {5'(2 + INC), 8'h0b}) begin
      n_err++;
      $display("FAIL wr_second: got addr %h data %h expected addr %h data 0b",
               wr_addr[wb+1], wr_data[wb+1], 5'(2 + INC));
    end
    n_cmp++;
    if (n_reads - rb !== 0) begin
      n_err++;
      $display("FAIL wr_no_read: got %0d reads expected 0", n_reads - rb);
    end
    n_cmp++;
    if ({rx0, rx1, rx2} !== 24'h0) begin
      n_err++;
      $display("FAIL wr_miso_quiet: got %h expected 000000", {rx0, rx1, rx2});
    end
  endtask

  task automatic test_read_single();
    logic [7:0] rx;
    int rb;
    rb      = n_reads;
    rd_base = n_reads;
    rd_vals = '{8'h0f, 8'hee, 8'hee, 8'hee};
    start_frame();
    spi_bits(8'h00, 8, rx);
    spi_bits(8'h00, 8, rx);
    end_frame();
    n_cmp++;
    if (rx !== 8'h0f) begin
      n_err++;
      $display("FAIL rd1_miso: got %h expected 0f", rx);
    end
    n_cmp++;
    if (n_reads - rb !== 1) begin
      n_err++;
      $display("FAIL rd1_count: got %0d expected 1", n_reads - rb);
    end
    n_cmp++;
    if (rd_addr[rb] !== 5'h00) begin
      n_err++;
      $display("FAIL rd1_addr: got %h expected 00", rd_addr[rb]);
    end
  endtask

  task automatic test_read_burst();
    logic [7:0] rx;
    logic [7:0] exp_b [3];
    int rb, wb;
    exp_b   = '{8'h11, 8'h22, 8'h33};
    rb      = n_reads;
    wb      = n_writes;
    rd_base = n_reads;
    rd_vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_frame();
    spi_bits(8'h15, 8, rx);
    for (int b = 0; b < 3; b++) begin
      spi_bits(8'h00, 8, rx);
      n_cmp++;
      if (rx !== exp_b[b]) begin
        n_err++;
        $display("FAIL rdb_miso_%0d: got %h expected %h", b, rx, exp_b[b]);
      end
    end
    end_frame();
    n_cmp++;
    if (n_reads - rb !== 3) begin
      n_err++;
      $display("FAIL rdb_count: got %0d expected 3", n_reads - rb);
    end
    n_cmp++;
    if ({rd_addr[rb], rd_addr[rb+1], rd_addr[rb+2]} !== {5'h15, 5'h15, 5'h15}) begin
      n_err++;
      $display("FAIL rdb_addr: got %h %h %h expected 15 15 15", rd_addr[rb], rd_addr[rb+1], rd_addr[rb+2]);
    end
    n_cmp++;
    if (n_writes - wb !== 0) begin
      n_err++;
      $display("FAIL rdb_no_write: got %0d expected 0", n_writes - wb);
    end
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    int wb;
    wb = n_writes;
    start_frame();
    spi_bits(8'h95, 8, rx);
    spi_bits(8'hff, 5, rx);
    tick(2);
    spi_ss_n = 1'b1;
    tick(SYNC_STAGES + 1);
    n_cmp++;
    if ({chip_select, spi_miso_oe} !== 2'b00) begin
      n_err++;
      $display("FAIL abort_deselect: got %b expected 00", {chip_select, spi_miso_oe});
    end
    tick(4);
    n_cmp++;
    if (n_writes - wb !== 0) begin
      n_err++;
      $display("FAIL abort_no_write: got %0d expected 0", n_writes - wb);
    end
    // A fresh frame must start from bit 0 of a new command byte.
    start_frame();
    spi_bits(8'h83, 8, rx);
    spi_bits(8'h5a, 8, rx);
    end_frame();
    n_cmp++;
    if ({5'(n_writes - wb), wr_addr[wb], wr_data[wb]} !== {5'd1, 5'h03, 8'h5a}) begin
      n_err++;
      $display("FAIL abort_recover: got n %0d addr %h data %h expected n 1 addr 03 data 5a",
               n_writes - wb, wr_addr[wb], wr_data[wb]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx;
    logic [17:0] outs;
    int wb;
    wb = n_writes;
    start_frame();
    spi_bits(8'h84, 8, rx);
    spi_bits(8'hf0, 4, rx);
    tick(2);
    reset_n = 1'b0;
    #1;
    outs = {spi_miso, spi_miso_oe, chip_select, csr_address, csr_read, csr_write, csr_writedata};
    n_cmp++;
    if (outs !== 18'h0) begin
      n_err++;
      $display("FAIL rst_mid_outputs: got %h expected 00000", outs);
    end
    tick(3);
    reset_n = 1'b1;
    spi_bits(8'h0f, 4, rx);
    spi_bits(8'h99, 8, rx);
    n_cmp++;
    if ({5'(n_writes - wb), chip_select} !== {5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL rst_ignore_frame: got writes %0d cs %b expected writes 0 cs 0", n_writes - wb, chip_select);
    end
    end_frame();
    start_frame();
    spi_bits(8'h86, 8, rx);
    spi_bits(8'h77, 8, rx);
    end_frame();
    n_cmp++;
    if ({5'(n_writes - wb), wr_addr[wb], wr_data[wb]} !== {5'd1, 5'h06, 8'h77}) begin
      n_err++;
      $display("FAIL rst_recover: got n %0d addr %h data %h expected n 1 addr 06 data 77",
               n_writes - wb, wr_addr[wb], wr_data[wb]);
    end
  endtask

  task automatic test_auto_inc();
    logic [7:0] rx;
    int wb;
    wb = n_writes;
    start_frame();
    spi_bits(8'h8c, 8, rx);
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h02, 8, rx);
    end_frame();
    start_frame();
    spi_bits(8'h95, 8, rx);
    spi_bits(8'h01, 8, rx);
    spi_bits(8'h02, 8, rx);
    end_frame();
    n_cmp++;
    if (n_writes - wb !== 4) begin
      n_err++;
      $display("FAIL inc_count: got %0d expected 4", n_writes - wb);
    end
    n_cmp++;
    if ({wr_addr[wb], wr_addr[wb+1]} !== {5'h0c, 5'(12 + INC)}) begin
      n_err++;
      $display("FAIL inc_addr_0c: got %h %h expected 0c %h", wr_addr[wb], wr_addr[wb+1], 5'(12 + INC));
    end
    n_cmp++;
    if ({wr_addr[wb+2], wr_addr[wb+3]} !== {5'h15, 5'h15}) begin
      n_err++;
      $display("FAIL inc_addr_fifo: got %h %h expected 15 15", wr_addr[wb+2], wr_addr[wb+3]);
    end
    n_cmp++;
    if ({wr_data[wb], wr_data[wb+1], wr_data[wb+2], wr_data[wb+3]} !== 32'h01020102) begin
      n_err++;
      $display("FAIL inc_data: got %h %h %h %h expected 01 02 01 02",
               wr_data[wb], wr_data[wb+1], wr_data[wb+2], wr_data[wb+3]);
    end
  endtask

  task automatic test_no_overlap();
    n_cmp++;
    if (both_err !== 0) begin
      n_err++;
      $display("FAIL strobe_overlap: got %0d cycles with both strobes expected 0", both_err);
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_single();
    test_read_burst();
    test_abort();
    test_reset_mid();
    test_auto_inc();
    test_no_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
